// File: rtl/barcode_entry_controller_if.sv
// barcode_entry_controller_if
// Bundles the keypad, shift-register and lookup signals of the barcode entry
// controller.
//   slave  : the controller (consumes key/lookup inputs, drives the rest)
//   master : the surrounding logic / keypad / lookup side
// Signals:
//   KEY_VALID, KEY_CODE        held key from the keypad decoder
//   LOOKUP_DONE, LOOKUP_FOUND  lookup completion pulse and result
//   SR_DIGIT, SR_ENABLE        digit and shift strobe to the barcode register
//   SR_RESET_N                 active-low synchronous clear to the register
//   DIGIT_COUNT                digits accepted so far (0..4)
//   LOOKUP_REQ                 request held until LOOKUP_DONE
//   ITEM_ACCEPTED, ENTRY_ERROR, TIMEOUT   single-cycle event pulses
interface barcode_entry_controller_if;
    logic       KEY_VALID;
    logic [3:0] KEY_CODE;
    logic       LOOKUP_DONE;
    logic       LOOKUP_FOUND;
    logic [3:0] SR_DIGIT;
    logic       SR_ENABLE;
    logic       SR_RESET_N;
    logic [2:0] DIGIT_COUNT;
    logic       LOOKUP_REQ;
    logic       ITEM_ACCEPTED;
    logic       ENTRY_ERROR;
    logic       TIMEOUT;

    modport slave (
        input  KEY_VALID, KEY_CODE, LOOKUP_DONE, LOOKUP_FOUND,
        output SR_DIGIT, SR_ENABLE, SR_RESET_N, DIGIT_COUNT,
               LOOKUP_REQ, ITEM_ACCEPTED, ENTRY_ERROR, TIMEOUT
    );

    modport master (
        output KEY_VALID, KEY_CODE, LOOKUP_DONE, LOOKUP_FOUND,
        input  SR_DIGIT, SR_ENABLE, SR_RESET_N, DIGIT_COUNT,
               LOOKUP_REQ, ITEM_ACCEPTED, ENTRY_ERROR, TIMEOUT
    );
endinterface

// File: rtl/barcode_entry_controller.sv
// barcode_entry_controller
// Turns held keypad codes into single shift strobes for a 4-digit barcode
// register, clears the register on CLEAR/completion, and runs a request/done
// handshake with the product lookup block.
// Ports:
//   CLOCK    system clock
//   RESET_N  asynchronous active-low reset
//   bus      barcode_entry_controller_if.slave (key, lookup and register signals)
// Optional feature: define BARCODE_TIMEOUT_EN to enable the inactivity
// timeout in COLLECT (TIMEOUT_CYCLES, counter width CNT_W). Without it the
// TIMEOUT output is tied low and no counter exists.
//
// state   | meaning
// IDLE    | no digits collected, waiting for keys
// COLLECT | 1..4 digits collected, waiting for more digits / ENTER / CLEAR
// LOOKUP  | LOOKUP_REQ high, keys ignored until LOOKUP_DONE
module barcode_entry_controller #(
    parameter int TIMEOUT_CYCLES = 250000000,
    parameter int CNT_W          = 28
) (
    input  logic                             CLOCK,
    input  logic                             RESET_N,
    barcode_entry_controller_if.slave        bus
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_LOOKUP  = 2'd2;

    localparam logic [3:0] CODE_CLEAR = 4'hA;
    localparam logic [3:0] CODE_ENTER = 4'hB;
    localparam logic [2:0] MAX_DIGITS = 3'd4;

    if ((64'(TIMEOUT_CYCLES) >> CNT_W) != 64'd0) begin : g_cnt_w_check
        $error("CNT_W too narrow for TIMEOUT_CYCLES");
    end

    logic [1:0] state;
    logic       key_q;
    logic       evt_q;
    logic [3:0] code_q;
    logic [3:0] sr_digit;
    logic       sr_enable;
    logic       sr_reset_n;
    logic [2:0] digit_count;
    logic       lookup_req;
    logic       item_accepted;
    logic       entry_error;
    logic       timeout;

    logic is_digit;
    logic is_clear;
    logic is_enter;
    logic key_accept;
    logic timeout_hit;

    assign is_digit   = (code_q <= 4'd9);
    assign is_clear   = (code_q == CODE_CLEAR);
    assign is_enter   = (code_q == CODE_ENTER);
    // Keys are dead in LOOKUP; codes C..F are never acted on.
    assign key_accept = evt_q && (state != ST_LOOKUP) && (is_digit || is_clear || is_enter);

`ifdef BARCODE_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            tmo_cnt <= '0;
        end else if ((state != ST_COLLECT) || key_accept || timeout_hit) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // A key handled in the terminal cycle takes priority over the timeout.
    assign timeout_hit = (state == ST_COLLECT) && (tmo_cnt == TMO_LAST) && !key_accept;
`else
    assign timeout_hit = 1'b0;
`endif

    // Rising-edge detect; the code is captured with the edge so the FSM
    // acts on it one clock later.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            key_q  <= 1'b0;
            evt_q  <= 1'b0;
            code_q <= 4'd0;
        end else begin
            key_q  <= bus.KEY_VALID;
            evt_q  <= bus.KEY_VALID & ~key_q;
            code_q <= bus.KEY_CODE;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state         <= ST_IDLE;
            sr_digit      <= 4'd0;
            sr_enable     <= 1'b0;
            sr_reset_n    <= 1'b0;
            digit_count   <= 3'd0;
            lookup_req    <= 1'b0;
            item_accepted <= 1'b0;
            entry_error   <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            sr_enable     <= 1'b0;
            sr_reset_n    <= 1'b1;
            item_accepted <= 1'b0;
            entry_error   <= 1'b0;
            timeout       <= 1'b0;

            case (state)
                ST_IDLE, ST_COLLECT: begin
                    if (key_accept) begin
                        if (is_digit) begin
                            if (digit_count < MAX_DIGITS) begin
                                sr_digit    <= code_q;
                                sr_enable   <= 1'b1;
                                digit_count <= digit_count + 3'd1;
                                state       <= ST_COLLECT;
                            end else begin
                                entry_error <= 1'b1;
                            end
                        end else if (is_clear) begin
                            sr_reset_n  <= 1'b0;
                            digit_count <= 3'd0;
                            state       <= ST_IDLE;
                        end else if (digit_count == MAX_DIGITS) begin
                            lookup_req <= 1'b1;
                            state      <= ST_LOOKUP;
                        end else begin
                            entry_error <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        timeout     <= 1'b1;
                        sr_reset_n  <= 1'b0;
                        digit_count <= 3'd0;
                        state       <= ST_IDLE;
                    end
                end
                ST_LOOKUP: begin
                    if (bus.LOOKUP_DONE) begin
                        lookup_req    <= 1'b0;
                        sr_reset_n    <= 1'b0;
                        digit_count   <= 3'd0;
                        item_accepted <= bus.LOOKUP_FOUND;
                        entry_error   <= ~bus.LOOKUP_FOUND;
                        state         <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.SR_DIGIT      = sr_digit;
    assign bus.SR_ENABLE     = sr_enable;
    assign bus.SR_RESET_N    = sr_reset_n;
    assign bus.DIGIT_COUNT   = digit_count;
    assign bus.LOOKUP_REQ    = lookup_req;
    assign bus.ITEM_ACCEPTED = item_accepted;
    assign bus.ENTRY_ERROR   = entry_error;
    assign bus.TIMEOUT       = timeout;
endmodule

// File: tb/tb_barcode_entry_controller.sv
// tb_barcode_entry_controller
// Directed bench for barcode_entry_controller. A negedge monitor counts
// high cycles of each strobe and records shifted digits; each scenario task
// compares those counts and the level outputs against hand-derived values.
module tb_barcode_entry_controller;
    logic CLOCK;
    logic RESET_N;

    barcode_entry_controller_if bus();

    barcode_entry_controller #(
        .TIMEOUT_CYCLES(20),
        .CNT_W(5)
    ) dut (
        .CLOCK(CLOCK),
        .RESET_N(RESET_N),
        .bus(bus)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    int total = 0;
    int bad   = 0;

    int en_cnt, err_cnt, acc_cnt, rlow_cnt, tmo_cnt;
    logic [3:0] dig_q[$];

    always @(negedge CLOCK) begin
        if (RESET_N) begin
            if (bus.SR_ENABLE) begin
                en_cnt++;
                dig_q.push_back(bus.SR_DIGIT);
            end
            if (bus.ENTRY_ERROR)   err_cnt++;
            if (bus.ITEM_ACCEPTED) acc_cnt++;
            if (!bus.SR_RESET_N)   rlow_cnt++;
            if (bus.TIMEOUT)       tmo_cnt++;
        end
    end

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic clear_mon();
        en_cnt = 0; err_cnt = 0; acc_cnt = 0; rlow_cnt = 0; tmo_cnt = 0;
        dig_q.delete();
    endtask

    task automatic press(input logic [3:0] code);
        bus.KEY_CODE  = code;
        bus.KEY_VALID = 1'b1;
        repeat (5) tick();
        bus.KEY_VALID = 1'b0;
        repeat (3) tick();
    endtask

    task automatic done_pulse(input logic found);
        bus.LOOKUP_DONE  = 1'b1;
        bus.LOOKUP_FOUND = found;
        tick();
        bus.LOOKUP_DONE  = 1'b0;
        bus.LOOKUP_FOUND = 1'b0;
        repeat (3) tick();
    endtask

    task automatic enter_four();
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        press(4'hB);
    endtask

    task automatic test_reset();
        bus.KEY_VALID = 0; bus.KEY_CODE = 0; bus.LOOKUP_DONE = 0; bus.LOOKUP_FOUND = 0;
        RESET_N = 1'b0;
        repeat (3) tick();
        total++; if (bus.SR_RESET_N !== 1'b0) begin bad++; $display("FAIL rst_sr_reset_n got %b want 0", bus.SR_RESET_N); end
        total++; if (bus.DIGIT_COUNT !== 3'd0) begin bad++; $display("FAIL rst_count got %0d want 0", bus.DIGIT_COUNT); end
        total++; if (bus.LOOKUP_REQ !== 1'b0) begin bad++; $display("FAIL rst_req got %b want 0", bus.LOOKUP_REQ); end
        total++; if ({bus.SR_ENABLE, bus.ITEM_ACCEPTED, bus.ENTRY_ERROR, bus.TIMEOUT} !== 4'b0) begin
            bad++; $display("FAIL rst_strobes got %b want 0000", {bus.SR_ENABLE, bus.ITEM_ACCEPTED, bus.ENTRY_ERROR, bus.TIMEOUT}); end
        RESET_N = 1'b1;
        #1;
        total++; if (bus.SR_RESET_N !== 1'b0) begin bad++; $display("FAIL rel_sr_reset_n_early got %b want 0", bus.SR_RESET_N); end
        tick();
        total++; if (bus.SR_RESET_N !== 1'b1) begin bad++; $display("FAIL rel_sr_reset_n got %b want 1", bus.SR_RESET_N); end
        tick();
        clear_mon();
    endtask

    task automatic test_full_entry();
        logic [3:0] exp_d [4] = '{4'd1, 4'd2, 4'd3, 4'd4};
        clear_mon();
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        total++; if (en_cnt !== 4) begin bad++; $display("FAIL entry_en_cycles got %0d want 4", en_cnt); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (dig_q.size() <= i || dig_q[i] !== exp_d[i]) begin
                bad++; $display("FAIL entry_digit%0d got %0h want %0h", i, (dig_q.size() > i) ? dig_q[i] : 4'hx, exp_d[i]);
            end
        end
        total++; if (bus.DIGIT_COUNT !== 3'd4) begin bad++; $display("FAIL entry_count got %0d want 4", bus.DIGIT_COUNT); end
        total++; if (bus.LOOKUP_REQ !== 1'b0) begin bad++; $display("FAIL entry_req_early got %b want 0", bus.LOOKUP_REQ); end
        press(4'hB);
        repeat (10) tick();
        total++; if (bus.LOOKUP_REQ !== 1'b1) begin bad++; $display("FAIL entry_req got %b want 1", bus.LOOKUP_REQ); end
        total++; if (err_cnt !== 0 || rlow_cnt !== 0) begin bad++; $display("FAIL entry_no_err got err=%0d rlow=%0d want 0 0", err_cnt, rlow_cnt); end
    endtask

    task automatic test_lookup_result();
        clear_mon();
        done_pulse(1'b1);
        total++; if (bus.LOOKUP_REQ !== 1'b0) begin bad++; $display("FAIL found_req got %b want 0", bus.LOOKUP_REQ); end
        total++; if (acc_cnt !== 1 || err_cnt !== 0) begin bad++; $display("FAIL found_pulses got acc=%0d err=%0d want 1 0", acc_cnt, err_cnt); end
        total++; if (rlow_cnt !== 1) begin bad++; $display("FAIL found_clear got %0d want 1", rlow_cnt); end
        total++; if (bus.DIGIT_COUNT !== 3'd0) begin bad++; $display("FAIL found_count got %0d want 0", bus.DIGIT_COUNT); end
        enter_four();
        clear_mon();
        done_pulse(1'b0);
        total++; if (acc_cnt !== 0 || err_cnt !== 1) begin bad++; $display("FAIL notfound_pulses got acc=%0d err=%0d want 0 1", acc_cnt, err_cnt); end
        total++; if (rlow_cnt !== 1 || bus.LOOKUP_REQ !== 1'b0) begin bad++; $display("FAIL notfound_clear got rlow=%0d req=%b want 1 0", rlow_cnt, bus.LOOKUP_REQ); end
    endtask

    task automatic test_short_enter();
        clear_mon();
        press(4'd7); press(4'd8); press(4'hB);
        total++; if (err_cnt !== 1) begin bad++; $display("FAIL short_err got %0d want 1", err_cnt); end
        total++; if (bus.LOOKUP_REQ !== 1'b0) begin bad++; $display("FAIL short_req got %b want 0", bus.LOOKUP_REQ); end
        total++; if (bus.DIGIT_COUNT !== 3'd2) begin bad++; $display("FAIL short_count got %0d want 2", bus.DIGIT_COUNT); end
        press(4'hA);
        total++; if (rlow_cnt !== 1 || en_cnt !== 2) begin bad++; $display("FAIL clear_pulse got rlow=%0d en=%0d want 1 2", rlow_cnt, en_cnt); end
        total++; if (bus.DIGIT_COUNT !== 3'd0) begin bad++; $display("FAIL clear_count got %0d want 0", bus.DIGIT_COUNT); end
    endtask

    task automatic test_overflow();
        clear_mon();
        for (int d = 1; d <= 5; d++) press(4'(d));
        total++; if (en_cnt !== 4 || err_cnt !== 1) begin bad++; $display("FAIL ovf_pulses got en=%0d err=%0d want 4 1", en_cnt, err_cnt); end
        total++; if (dig_q.size() != 4 || dig_q[3] !== 4'd4) begin bad++; $display("FAIL ovf_last_digit got size=%0d want 4 digits ending in 4", dig_q.size()); end
        total++; if (bus.DIGIT_COUNT !== 3'd4) begin bad++; $display("FAIL ovf_count got %0d want 4", bus.DIGIT_COUNT); end
        press(4'hB);
        clear_mon();
        press(4'hA);
        press(4'd9);
        total++; if (rlow_cnt !== 0 || en_cnt !== 0 || bus.DIGIT_COUNT !== 3'd4) begin
            bad++; $display("FAIL lookup_keys_ignored got rlow=%0d en=%0d count=%0d want 0 0 4", rlow_cnt, en_cnt, bus.DIGIT_COUNT); end
        total++; if (bus.LOOKUP_REQ !== 1'b1) begin bad++; $display("FAIL lookup_req_held got %b want 1", bus.LOOKUP_REQ); end
        done_pulse(1'b1);
    endtask

    task automatic test_ignored();
        clear_mon();
        done_pulse(1'b1);
        press(4'hC); press(4'hF);
        total++; if (acc_cnt !== 0 || err_cnt !== 0 || en_cnt !== 0 || rlow_cnt !== 0) begin
            bad++; $display("FAIL ignored_events got acc=%0d err=%0d en=%0d rlow=%0d want 0 0 0 0", acc_cnt, err_cnt, en_cnt, rlow_cnt); end
        total++; if (bus.DIGIT_COUNT !== 3'd0 || bus.LOOKUP_REQ !== 1'b0) begin
            bad++; $display("FAIL ignored_state got count=%0d req=%b want 0 0", bus.DIGIT_COUNT, bus.LOOKUP_REQ); end
    endtask

    task automatic test_simultaneous();
        enter_four();
        clear_mon();
        // Key rises one cycle before DONE so the FSM sees both together.
        bus.KEY_CODE  = 4'd5;
        bus.KEY_VALID = 1'b1;
        tick();
        bus.LOOKUP_DONE  = 1'b1;
        bus.LOOKUP_FOUND = 1'b1;
        tick();
        bus.LOOKUP_DONE  = 1'b0;
        bus.LOOKUP_FOUND = 1'b0;
        repeat (3) tick();
        bus.KEY_VALID = 1'b0;
        repeat (3) tick();
        total++; if (en_cnt !== 0 || bus.DIGIT_COUNT !== 3'd0) begin
            bad++; $display("FAIL simul_discard got en=%0d count=%0d want 0 0", en_cnt, bus.DIGIT_COUNT); end
        total++; if (acc_cnt !== 1 || bus.LOOKUP_REQ !== 1'b0) begin
            bad++; $display("FAIL simul_done got acc=%0d req=%b want 1 0", acc_cnt, bus.LOOKUP_REQ); end
    endtask

    task automatic test_timeout();
        clear_mon();
        press(4'd3);
        total++; if (tmo_cnt !== 0 || bus.DIGIT_COUNT !== 3'd1) begin
            bad++; $display("FAIL tmo_early got tmo=%0d count=%0d want 0 1", tmo_cnt, bus.DIGIT_COUNT); end
        repeat (30) tick();
`ifdef BARCODE_TIMEOUT_EN
        total++; if (tmo_cnt !== 1 || rlow_cnt !== 1) begin bad++; $display("FAIL tmo_pulse got tmo=%0d rlow=%0d want 1 1", tmo_cnt, rlow_cnt); end
        total++; if (bus.DIGIT_COUNT !== 3'd0) begin bad++; $display("FAIL tmo_count got %0d want 0", bus.DIGIT_COUNT); end
`else
        total++; if (tmo_cnt !== 0 || rlow_cnt !== 0) begin bad++; $display("FAIL tmo_off got tmo=%0d rlow=%0d want 0 0", tmo_cnt, rlow_cnt); end
        total++; if (bus.DIGIT_COUNT !== 3'd1) begin bad++; $display("FAIL tmo_off_count got %0d want 1", bus.DIGIT_COUNT); end
        press(4'hA);
`endif
    endtask

    task automatic test_reset_in_lookup();
        enter_four();
        total++; if (bus.LOOKUP_REQ !== 1'b1) begin bad++; $display("FAIL arst_pre_req got %b want 1", bus.LOOKUP_REQ); end
        #2;
        RESET_N = 1'b0;
        #1;
        total++; if (bus.LOOKUP_REQ !== 1'b0) begin bad++; $display("FAIL arst_req got %b want 0", bus.LOOKUP_REQ); end
        total++; if (bus.DIGIT_COUNT !== 3'd0 || bus.SR_RESET_N !== 1'b0) begin
            bad++; $display("FAIL arst_state got count=%0d sr_reset_n=%b want 0 0", bus.DIGIT_COUNT, bus.SR_RESET_N); end
        tick();
        RESET_N = 1'b1;
        repeat (2) tick();
        clear_mon();
        press(4'd6);
        total++; if (en_cnt !== 1 || bus.DIGIT_COUNT !== 3'd1) begin
            bad++; $display("FAIL arst_recover got en=%0d count=%0d want 1 1", en_cnt, bus.DIGIT_COUNT); end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_full_entry();
        test_lookup_result();
        test_short_enter();
        test_overflow();
        test_ignored();
        test_simultaneous();
        test_timeout();
        test_reset_in_lookup();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
